stc_abuf_ctrl: RTL and testbench
================================

Name: stc_abuf_ctrl

Overview:
Sequencer for the sparse-A operand buffer (stc_Abuffer) of the unstructured sparse tensor core. It accepts M row beats of A values and M row beats of column indices, with a per-row nonzero count, from a valid/ready memory stream, and drives the buffer write ports. It then walks the stored nonzeros row by row and issues LANES flat pointers per cycle to the buffer read port, with lane-valid masks for the downstream dot-product lanes.

Parameters:
M, 16, rows of A tile
K, 16, elements per row (max nnz per row)
DW_MEM, 256, memory beat width (K*DW_DATA)
DW_DATA, 16, value width
DW_COL, 4, row/column index width (log2 M, log2 K)
DW_PTR, 8, flat pointer width (log2 M*K)
DW_NNZ, 5, per-row nnz count width (log2(K+1))
LANES, 4, pointers issued per cycle

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin load+issue of one tile; sampled in IDLE only
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when the tile is finished
in_valid  input  1  memory beat valid
in_ready  output  1  controller accepts beat
in_data  input  DW_MEM  A values row beat (LOAD_DATA phase)
in_cidx  input  DW_MEM  column-index row beat (LOAD_CIDX phase)
in_nnz  input  DW_NNZ  nonzeros in the row, sampled with the cidx beat
buf_write_data_en  output  1  to buffer write_data_en
buf_write_cidx_en  output  1  to buffer write_cidx_en
buf_data  output  DW_MEM  to buffer A_data_input
buf_cidx  output  DW_MEM  to buffer A_colidx_input
buf_idx  output  DW_COL  to buffer idx (row being written)
buf_ptrs  output  DW_PTR*LANES  to buffer ptrs; lane j at [j*DW_PTR +: DW_PTR]
out_valid  output  1  issue group valid
out_ready  input  1  downstream accepts issue group
out_lane_valid  output  LANES  per-lane valid mask
out_row  output  DW_COL  row of current issue group
out_last  output  1  last issue group of the tile

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; row/offset counters and nnz array cleared. Reset mid-tile aborts; no done pulse.
- States: IDLE -> LOAD_DATA -> LOAD_CIDX -> ISSUE -> IDLE.
- IDLE: in_ready=0. start=1 -> LOAD_DATA, row counter r=0. start outside IDLE is ignored.
- LOAD_DATA: in_ready=1. Beat accepted (in_valid&in_ready) at cycle t -> at t+1 buf_write_data_en=1, buf_data=in_data, buf_idx=r; r increments. After beat M-1 -> LOAD_CIDX, r=0.
- LOAD_CIDX: same timing with buf_write_cidx_en, buf_cidx=in_cidx; nnz[r]=min(in_nnz,K) (values >K clamp to K). After beat M-1 -> ISSUE.
- Write enables are single-cycle pulses; buf_data/buf_cidx/buf_idx hold their last value otherwise. in_valid without in_ready is ignored.
- ISSUE: first group is registered, so out_valid rises at t+2 where t is the acceptance of the last cidx beat, i.e. one cycle after the final buffer write.
- Group at (row r, offset o): lane j ptr = r*K+o+j (mod 2^DW_PTR); out_lane_valid[j] = (o+j < nnz[r]); invalid lanes still carry a ptr value; out_row=r.
- Advance on out_valid&out_ready: o+=LANES; if o>=nnz[r] go to the next row with nnz>0, o=0. Rows with nnz=0 are skipped with no bubble (priority search over the nnz array).
- out_last=1 on the group after which no nonzero remains. Its handshake -> out_valid=0, done=1 for 1 cycle, -> IDLE.
- Stall: while out_valid&!out_ready, buf_ptrs, out_lane_valid, out_row and out_last hold stable.
- All rows nnz=0: ISSUE raises no out_valid; done pulses the cycle after entering ISSUE; -> IDLE.
- Groups never span two rows. Issue cycles per tile = sum over rows of ceil(nnz[r]/LANES) with out_ready held high.

Decomposition:
- Package stc_abuf_pkg: state encoding (IDLE, LOAD_DATA, LOAD_CIDX, ISSUE), defaults for M/K/LANES, derived widths DW_COL/DW_PTR/DW_NNZ as localparams.
- Sub-module stc_nnz_next_row: combinational priority finder returning the next row index >r with nnz>0, plus a none-found flag.

Test Plan:
- Reset mid-LOAD_DATA after 5 beats -> all outputs 0 immediately; new start reloads from buf_idx=0; no done.
- Full load, nnz all 16, out_ready=1 -> 64 groups; row 0 ptrs {0,1,2,3},{4..7}…; row 15 last group ptrs {252..255} with out_last=1; done 1 cycle after.
- nnz={5,0,0,3,0…0} -> groups: row0 ptrs 0..3 mask 1111; row0 ptrs 4..7 mask 0001; row3 ptrs 48..51 mask 0111 with out_last; 3 issue cycles.
- All nnz=0 -> no out_valid; done pulses the cycle after the final buffer write.
- out_ready toggled 1/0 randomly with nnz=7 per row -> ptrs stable during stall; each group issued exactly once; 32 handshakes.
- in_valid gaps during load and in_nnz=20 on row 2 -> buf_idx increments only on accepted beats; row 2 issued as 16 nonzeros (4 full groups).

Source files
------------

// File: rtl/stc_abuf_ctrl_pkg.sv
// Shared types and tile geometry for the sparse-A operand buffer sequencer.
// Derived widths follow from the tile geometry so every file agrees on them.
package stc_abuf_pkg;

  localparam int M       = 16;
  localparam int K       = 16;
  localparam int DW_DATA = 16;
  localparam int LANES   = 4;

  localparam int DW_MEM  = K * DW_DATA;
  localparam int DW_COL  = $clog2(M);
  localparam int DW_PTR  = $clog2(M * K);
  localparam int DW_NNZ  = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_DATA = 2'd1,
    LOAD_CIDX = 2'd2,
    ISSUE     = 2'd3
  } state_t;

endpackage

// File: rtl/stc_abuf_ctrl_if.sv
// Memory stream, buffer write/read port and issue-group bus of the A-buffer sequencer.
// The master side is the controller; the slave side is memory, buffer and lanes.
interface stc_abuf_ctrl_if;
  import stc_abuf_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DW_MEM-1:0]       in_data;
  logic [DW_MEM-1:0]       in_cidx;
  logic [DW_NNZ-1:0]       in_nnz;

  logic                    buf_write_data_en;
  logic                    buf_write_cidx_en;
  logic [DW_MEM-1:0]       buf_data;
  logic [DW_MEM-1:0]       buf_cidx;
  logic [DW_COL-1:0]       buf_idx;
  logic [DW_PTR*LANES-1:0] buf_ptrs;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_lane_valid;
  logic [DW_COL-1:0]       out_row;
  logic                    out_last;

  modport master (
    input  in_valid, in_data, in_cidx, in_nnz, out_ready,
    output in_ready,
    output buf_write_data_en, buf_write_cidx_en, buf_data, buf_cidx, buf_idx, buf_ptrs,
    output out_valid, out_lane_valid, out_row, out_last
  );

  modport slave (
    output in_valid, in_data, in_cidx, in_nnz, out_ready,
    input  in_ready,
    input  buf_write_data_en, buf_write_cidx_en, buf_data, buf_cidx, buf_idx, buf_ptrs,
    input  out_valid, out_lane_valid, out_row, out_last
  );

endinterface

// File: rtl/stc_abuf_ctrl_nnz_next_row.sv
// Priority finder: lowest row index strictly above 'row' whose nonzero count is non-zero.
// 'none' is set when no such row exists; next_row is then 0.
module stc_nnz_next_row
  import stc_abuf_pkg::*;
(
  input  logic [M-1:0][DW_NNZ-1:0] nnz,
  input  logic [DW_COL-1:0]        row,
  output logic [DW_COL-1:0]        next_row,
  output logic                     none
);

  // NOTE: every output gets a default before the search so the block stays combinational (no latch).
  always_comb begin
    next_row = '0;
    none     = 1'b1;
    // Descending scan: the last hit written is the lowest qualifying row.
    for (int i = M - 1; i >= 0; i--) begin
      if (i > int'(row) && nnz[i] != '0) begin
        next_row = DW_COL'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stc_abuf_ctrl.sv
// Sparse-A buffer sequencer: loads M value beats and M column-index beats into the
// buffer, then walks stored nonzeros row by row issuing LANES flat pointers per cycle.
module stc_abuf_ctrl
  import stc_abuf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  stc_abuf_ctrl_if.master bus
);

  state_t                  state, state_nxt;
  logic [DW_COL-1:0]       row_cnt;
  logic [M-1:0][DW_NNZ-1:0] nnz;

  logic                    wr_data_en_q, wr_cidx_en_q;
  logic [DW_MEM-1:0]       buf_data_q, buf_cidx_q;
  logic [DW_COL-1:0]       buf_idx_q;

  logic                    out_valid_q, done_q;
  logic [DW_COL-1:0]       cur_row;
  logic [DW_NNZ-1:0]       cur_off;
  logic [DW_PTR*LANES-1:0] ptrs_q, ld_ptrs;
  logic [LANES-1:0]        mask_q, ld_mask;

  logic                    in_ready, in_fire, out_fire, row_wrap;
  logic [DW_COL-1:0]       search_row, nxt_row;
  logic                    nxt_none;
  logic                    row_end, grp_last;
  logic                    ld_en, tile_end;
  logic [DW_COL-1:0]       ld_row;
  logic [DW_NNZ-1:0]       ld_off;
  logic [DW_NNZ-1:0]       nnz_clamped;

  // Before the first group is loaded the search starts from row 0; row 0 itself is tested separately.
  assign search_row = out_valid_q ? cur_row : '0;

  stc_nnz_next_row u_next_row (
    .nnz      (nnz),
    .row      (search_row),
    .next_row (nxt_row),
    .none     (nxt_none)
  );

  assign in_fire     = bus.in_valid && in_ready;
  assign out_fire    = out_valid_q && bus.out_ready;
  assign row_wrap    = (row_cnt == DW_COL'(M - 1));
  assign row_end     = (int'(cur_off) + LANES) >= int'(nnz[cur_row]);
  assign grp_last    = row_end && nxt_none;
  assign nnz_clamped = (int'(bus.in_nnz) > K) ? DW_NNZ'(K) : bus.in_nnz;

  // Selects the next issue group; groups never cross a row boundary.
  always_comb begin
    ld_en    = 1'b0;
    tile_end = 1'b0;
    ld_row   = cur_row;
    ld_off   = cur_off;
    if (state == ISSUE) begin
      if (!out_valid_q) begin
        if (nnz[0] != '0) begin
          ld_en  = 1'b1;
          ld_row = '0;
          ld_off = '0;
        end else if (!nxt_none) begin
          ld_en  = 1'b1;
          ld_row = nxt_row;
          ld_off = '0;
        end else begin
          tile_end = 1'b1;
        end
      end else if (out_fire) begin
        if (grp_last) begin
          tile_end = 1'b1;
        end else if (!row_end) begin
          ld_en  = 1'b1;
          ld_off = cur_off + DW_NNZ'(LANES);
        end else begin
          ld_en  = 1'b1;
          ld_row = nxt_row;
          ld_off = '0;
        end
      end
    end
  end

  always_comb begin
    ld_ptrs = '0;
    ld_mask = '0;
    for (int j = 0; j < LANES; j++) begin
      ld_ptrs[j*DW_PTR +: DW_PTR] = DW_PTR'(int'(ld_row) * K + int'(ld_off) + j);
      ld_mask[j]                  = (int'(ld_off) + j) < int'(nnz[ld_row]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start)                state_nxt = LOAD_DATA;
      LOAD_DATA: if (in_fire && row_wrap) state_nxt = LOAD_CIDX;
      LOAD_CIDX: if (in_fire && row_wrap) state_nxt = ISSUE;
      ISSUE:     if (tile_end)             state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD_DATA) || (state == LOAD_CIDX);
    busy     = (state != IDLE);
  end

  // NOTE: the nnz array is cleared on reset because the row-skip search reads every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt      <= '0;
      nnz          <= '0;
      wr_data_en_q <= 1'b0;
      wr_cidx_en_q <= 1'b0;
      buf_data_q   <= '0;
      buf_cidx_q   <= '0;
      buf_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      cur_row      <= '0;
      cur_off      <= '0;
      ptrs_q       <= '0;
      mask_q       <= '0;
    end else begin
      wr_data_en_q <= 1'b0;
      wr_cidx_en_q <= 1'b0;
      done_q       <= 1'b0;

      if (state == IDLE && start) row_cnt <= '0;

      if (in_fire) begin
        buf_idx_q <= row_cnt;
        row_cnt   <= row_wrap ? '0 : row_cnt + DW_COL'(1);
        if (state == LOAD_DATA) begin
          wr_data_en_q <= 1'b1;
          buf_data_q   <= bus.in_data;
        end else begin
          wr_cidx_en_q  <= 1'b1;
          buf_cidx_q    <= bus.in_cidx;
          nnz[row_cnt]  <= nnz_clamped;
        end
      end

      if (ld_en) begin
        out_valid_q <= 1'b1;
        cur_row     <= ld_row;
        cur_off     <= ld_off;
        ptrs_q      <= ld_ptrs;
        mask_q      <= ld_mask;
      end

      if (tile_end) begin
        out_valid_q <= 1'b0;
        mask_q      <= '0;
        done_q      <= 1'b1;
      end
    end
  end

  assign done                  = done_q;
  assign bus.in_ready          = in_ready;
  assign bus.buf_write_data_en = wr_data_en_q;
  assign bus.buf_write_cidx_en = wr_cidx_en_q;
  assign bus.buf_data          = buf_data_q;
  assign bus.buf_cidx          = buf_cidx_q;
  assign bus.buf_idx           = buf_idx_q;
  assign bus.buf_ptrs          = ptrs_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_lane_valid    = mask_q;
  assign bus.out_row           = cur_row;
  assign bus.out_last          = out_valid_q && grp_last;

endmodule

// File: tb/tb_stc_abuf_ctrl.sv
// Directed bench for stc_abuf_ctrl: scoreboards buffer writes and issue groups against
// a model built from each tile's nnz table.
module tb_stc_abuf_ctrl;
  import stc_abuf_pkg::*;

  typedef struct {
    logic [DW_COL-1:0]       row;
    logic [DW_PTR*LANES-1:0] ptrs;
    logic [LANES-1:0]        mask;
    logic                    last;
  } grp_t;

  typedef struct {
    bit                cidx;
    logic [DW_COL-1:0] idx;
    logic [DW_MEM-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  stc_abuf_ctrl_if bus_if ();

  stc_abuf_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  grp_t gq[$];
  wr_t  wq[$];
  int   tile_nnz[M];

  task automatic check(input string tag, input logic [DW_MEM-1:0] obs, input logic [DW_MEM-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW_MEM-1:0] rand_beat();
    logic [DW_MEM-1:0] v;
    v = '0;
    for (int i = 0; i < DW_MEM / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_tile();
    check("idle_in_ready", bus_if.in_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Drives nbeats accepted beats; gap_pct is the chance of an idle in_valid cycle.
  task automatic load_phase(input bit is_cidx, input int gap_pct, input int nbeats);
    int  r = 0;
    int  guard = 0;
    wr_t w;
    while (r < nbeats && guard < 1000) begin
      guard++;
      bus_if.in_valid = ($urandom_range(99) >= gap_pct);
      bus_if.in_data  = rand_beat();
      bus_if.in_cidx  = rand_beat();
      bus_if.in_nnz   = DW_NNZ'(tile_nnz[r]);
      check(is_cidx ? "in_ready_cidx" : "in_ready_data", bus_if.in_ready, 1);
      if (bus_if.in_valid) begin
        w.cidx = is_cidx;
        w.idx  = DW_COL'(r);
        w.data = is_cidx ? bus_if.in_cidx : bus_if.in_data;
        wq.push_back(w);
      end
      tick();
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("wr_data_en", bus_if.buf_write_data_en, !w.cidx);
        check("wr_cidx_en", bus_if.buf_write_cidx_en, w.cidx);
        check("buf_idx", bus_if.buf_idx, w.idx);
        check(w.cidx ? "buf_cidx" : "buf_data", w.cidx ? bus_if.buf_cidx : bus_if.buf_data, w.data);
        r++;
      end else begin
        check("wr_data_en_idle", bus_if.buf_write_data_en, 0);
        check("wr_cidx_en_idle", bus_if.buf_write_cidx_en, 0);
      end
    end
    if (r < nbeats) check("load_timeout", r, nbeats);
    bus_if.in_valid = 1'b0;
  endtask

  // Called at the first ISSUE cycle (one cycle after the last cidx beat was accepted).
  task automatic issue_phase(input bit rand_ready);
    grp_t g;
    int   exp_issue = 0;
    int   hs = 0;
    int   cycles = 0;
    bit   rdy;
    gq.delete();
    for (int r = 0; r < M; r++) begin
      int n;
      n = (tile_nnz[r] > K) ? K : tile_nnz[r];
      exp_issue += (n + LANES - 1) / LANES;
      for (int o = 0; o < n; o += LANES) begin
        g.row = DW_COL'(r);
        for (int j = 0; j < LANES; j++) begin
          g.ptrs[j*DW_PTR +: DW_PTR] = DW_PTR'((r * K + o + j) % (1 << DW_PTR));
          g.mask[j] = (o + j) < n;
        end
        g.last = 1'b0;
        gq.push_back(g);
      end
    end
    if (gq.size() > 0) begin
      g = gq.pop_back();
      g.last = 1'b1;
      gq.push_back(g);
    end

    check("issue_entry_valid", bus_if.out_valid, 0);
    check("issue_entry_done", done, 0);
    tick();
    if (exp_issue == 0) begin
      check("empty_done_pulse", done, 1);
      check("empty_no_valid", bus_if.out_valid, 0);
      tick();
      check("empty_done_clear", done, 0);
      check("empty_idle", busy, 0);
    end else begin
      while (gq.size() > 0 && cycles < 4000) begin
        cycles++;
        g = gq[0];
        check("out_valid", bus_if.out_valid, 1);
        check("done_early", done, 0);
        check("out_row", bus_if.out_row, g.row);
        check("buf_ptrs", bus_if.buf_ptrs, g.ptrs);
        check("out_lane_valid", bus_if.out_lane_valid, g.mask);
        check("out_last", bus_if.out_last, g.last);
        rdy = rand_ready ? bit'($urandom_range(1)) : 1'b1;
        bus_if.out_ready = rdy;
        if (bus_if.out_valid && rdy) hs++;
        tick();
        if (rdy) void'(gq.pop_front());
      end
      if (gq.size() > 0) check("issue_timeout", gq.size(), 0);
      bus_if.out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("valid_after_last", bus_if.out_valid, 0);
      check("idle_after_done", busy, 0);
      check("handshakes", hs, exp_issue);
      if (!rand_ready) check("issue_cycles", cycles, exp_issue);
      tick();
      check("done_clear", done, 0);
    end
  endtask

  task automatic run_tile(input int gap_pct, input bit rand_ready);
    start_tile();
    load_phase(1'b0, gap_pct, M);
    load_phase(1'b1, gap_pct, M);
    issue_phase(rand_ready);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_cidx   = '0;
    bus_if.in_nnz    = '0;
    bus_if.out_ready = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus_if.in_ready, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_buf_ptrs", bus_if.buf_ptrs, 0);
    check("rst_buf_idx", bus_if.buf_idx, 0);
    reset = 1'b1;
    tick();

    // Reset in the middle of LOAD_DATA
    for (int r = 0; r < M; r++) tile_nnz[r] = 3;
    start_tile();
    load_phase(1'b0, 0, 5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", bus_if.in_ready, 0);
    check("mid_rst_wr_en", bus_if.buf_write_data_en, 0);
    check("mid_rst_buf_data", bus_if.buf_data, 0);
    check("mid_rst_buf_idx", bus_if.buf_idx, 0);
    check("mid_rst_out_valid", bus_if.out_valid, 0);
    wq.delete();
    tick();
    check("mid_rst_no_done", done, 0);
    reset = 1'b1;
    tick();
    check("mid_rst_no_done2", done, 0);

    // Dense tile: every row full
    for (int r = 0; r < M; r++) tile_nnz[r] = K;
    run_tile(0, 1'b0);

    // Sparse tile with empty rows skipped
    for (int r = 0; r < M; r++) tile_nnz[r] = 0;
    tile_nnz[0] = 5;
    tile_nnz[3] = 3;
    run_tile(0, 1'b0);

    // All rows empty
    for (int r = 0; r < M; r++) tile_nnz[r] = 0;
    run_tile(0, 1'b0);

    // Random backpressure
    for (int r = 0; r < M; r++) tile_nnz[r] = 7;
    run_tile(0, 1'b1);

    // Load gaps and an over-range nnz that must clamp
    for (int r = 0; r < M; r++) tile_nnz[r] = $urandom_range(K);
    tile_nnz[2]     = 20;
    tile_nnz[M - 1] = 0;
    run_tile(30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
